// File: rtl/data_unpacker.sv
// Width down-converter: splits each wide beat into narrow lanes, lane 0 first,
// trimming trailing lanes with keep and flagging the packet's final narrow beat.
module data_unpacker #(
  parameter  int InWidth   = 32,
  parameter  int OutWidth  = 8,
  localparam int Ratio     = InWidth / OutWidth,
  localparam int LaneWidth = $clog2(Ratio)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [InWidth-1:0]  writeData,
  input  logic [Ratio-1:0]    writeDataKeep,
  input  logic                writeDataValid,
  output logic                writeDataReady,
  input  logic                writeDataLast,
  output logic [OutWidth-1:0] readData,
  output logic                readDataValid,
  input  logic                readDataReady,
  output logic                readDataLast
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                          r_state;
  logic [InWidth-1:0]              r_holdData;
  logic                            r_holdLast;
  logic [LaneWidth-1:0]            r_lastLane;
  logic [LaneWidth-1:0]            r_laneIdx;

  logic [Ratio-1:0][OutWidth-1:0]  w_lanes;
  logic [LaneWidth-1:0]            w_hiLane;
  logic                            w_keepAny;
  logic                            w_finalLane;
  logic                            w_accept;
  logic                            w_xfer;

  // Highest set keep bit marks the last lane to emit; holes below it are ignored.
  always_comb begin
    w_hiLane = '0;
    for (int k = 0; k < Ratio; k++) begin
      if (writeDataKeep[k]) begin
        w_hiLane = LaneWidth'(k);
      end
    end
  end

  assign w_keepAny   = |writeDataKeep;
  assign w_lanes     = r_holdData;
  assign w_finalLane = (r_laneIdx == r_lastLane);

  // Reset gates ready so nothing looks acceptable while the block is held in reset.
  assign writeDataReady = ~reset & en &
                          ((r_state == IDLE) |
                           ((r_state == SHIFT) & w_finalLane & readDataReady));

  assign readData      = w_lanes[r_laneIdx];
  assign readDataValid = (r_state == SHIFT);
  assign readDataLast  = (r_state == SHIFT) & r_holdLast & w_finalLane;

  assign w_accept = writeDataValid & writeDataReady;
  assign w_xfer   = readDataValid & readDataReady;

  // Acceptance has priority: in SHIFT it only happens alongside the final-lane
  // transfer, so reloading here gives back-to-back beats with no bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_holdData <= '0;
      r_holdLast <= 1'b0;
      r_lastLane <= '0;
      r_laneIdx  <= '0;
    end else if (w_accept) begin
      r_holdData <= writeData;
      r_holdLast <= writeDataLast;
      r_lastLane <= w_hiLane;
      r_laneIdx  <= '0;
      r_state    <= w_keepAny ? SHIFT : IDLE;
    end else if (w_xfer) begin
      if (w_finalLane) begin
        r_state <= IDLE;
      end else begin
        r_laneIdx <= r_laneIdx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_unpacker.sv
// Self-checking bench for data_unpacker: directed scenarios plus random traffic,
// all compared against a queue of pending narrow lanes built from each accepted beat.
module tb_data_unpacker;

  logic        clk;
  logic        reset;
  logic        en;
  logic [31:0] writeData;
  logic [3:0]  writeDataKeep;
  logic        writeDataValid;
  logic        writeDataReady;
  logic        writeDataLast;
  logic [7:0]  readData;
  logic        readDataValid;
  logic        readDataReady;
  logic        readDataLast;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } lane_t;

  lane_t laneQ[$];
  int    checks = 0;
  int    errors = 0;

  data_unpacker #(.InWidth(32), .OutWidth(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .writeData      (writeData),
    .writeDataKeep  (writeDataKeep),
    .writeDataValid (writeDataValid),
    .writeDataReady (writeDataReady),
    .writeDataLast  (writeDataLast),
    .readData       (readData),
    .readDataValid  (readDataValid),
    .readDataReady  (readDataReady),
    .readDataLast   (readDataLast)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] %s comparison did not match", tag);
    end
  endtask

  // Outputs versus the pending-lane queue: valid while lanes remain, ready only
  // when idle or when the last pending lane leaves this edge.
  task automatic checkOutput(input string tag);
    logic expValid;
    logic expReady;
    expValid = (laneQ.size() != 0);
    expReady = en && ((laneQ.size() == 0) || ((laneQ.size() == 1) && readDataReady));
    checkVal({tag, ".valid"}, {31'b0, readDataValid}, {31'b0, expValid});
    checkVal({tag, ".ready"}, {31'b0, writeDataReady}, {31'b0, expReady});
    if (expValid) begin
      checkVal({tag, ".data"}, {24'b0, readData}, {24'b0, laneQ[0].data});
      checkVal({tag, ".last"}, {31'b0, readDataLast}, {31'b0, laneQ[0].last});
    end else begin
      checkVal({tag, ".lastIdle"}, {31'b0, readDataLast}, 32'd0);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check, then advance the model
  // by what the coming rising edge will do.
  task automatic applyStimulus(input string tag, input logic v, input logic [31:0] d,
                               input logic [3:0] k, input logic l, input logic e,
                               input logic r);
    logic xfer;
    logic accept;
    int   hi;
    @(negedge clk);
    writeDataValid = v;
    writeData      = d;
    writeDataKeep  = k;
    writeDataLast  = l;
    en             = e;
    readDataReady  = r;
    #1;
    checkOutput(tag);
    xfer   = (laneQ.size() != 0) && r;
    accept = v && e && ((laneQ.size() == 0) || ((laneQ.size() == 1) && r));
    if (xfer) void'(laneQ.pop_front());
    if (accept && (k != 4'b0)) begin
      hi = 0;
      for (int i = 0; i < 4; i++) if (k[i]) hi = i;
      for (int i = 0; i <= hi; i++) begin
        lane_t ln;
        ln.data = d[8*i +: 8];
        ln.last = l && (i == hi);
        laneQ.push_back(ln);
      end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus("idle", 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    logic [3:0] keepChoice [6];
    keepChoice = '{4'b1111, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};

    reset = 1'b1;
    en = 1'b1;
    writeData = '0;
    writeDataKeep = '0;
    writeDataValid = 1'b0;
    writeDataLast = 1'b0;
    readDataReady = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkVal("rst.valid", {31'b0, readDataValid}, 32'd0);
    checkVal("rst.ready", {31'b0, writeDataReady}, 32'd0);
    checkVal("rst.last",  {31'b0, readDataLast}, 32'd0);
    checkVal("rst.data",  {24'b0, readData}, 32'd0);
    reset = 1'b0;

    $display("[TB] single beat");
    applyStimulus("single", 1'b1, 32'hDDCCBBAA, 4'b1111, 1'b1, 1'b1, 1'b1);
    idleCycles(5);

    $display("[TB] back-to-back beats");
    applyStimulus("b2b", 1'b1, 32'h03020100, 4'b1111, 1'b0, 1'b1, 1'b1);
    repeat (3) applyStimulus("b2b", 1'b1, 32'h07060504, 4'b1111, 1'b1, 1'b1, 1'b1);
    applyStimulus("b2bSwap", 1'b1, 32'h07060504, 4'b1111, 1'b1, 1'b1, 1'b1);
    idleCycles(6);

    $display("[TB] partial final beat");
    applyStimulus("partial", 1'b1, 32'h11223344, 4'b0011, 1'b1, 1'b1, 1'b1);
    idleCycles(4);

    $display("[TB] backpressure");
    applyStimulus("bp", 1'b1, 32'hDDCCBBAA, 4'b1111, 1'b1, 1'b1, 1'b1);
    applyStimulus("bp", 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    applyStimulus("bp", 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus("bp", 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    checkVal("bp.holdBB", {24'b0, readData}, 32'h000000BB);
    applyStimulus("bp", 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    applyStimulus("bp", 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus("bp", 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    idleCycles(3);

    $display("[TB] zero keep and enable");
    applyStimulus("zeroKeep", 1'b1, 32'hFFEEDDCC, 4'b0000, 1'b1, 1'b1, 1'b1);
    repeat (3) applyStimulus("enLow", 1'b1, 32'h44332211, 4'b1111, 1'b1, 1'b0, 1'b1);
    applyStimulus("enHigh", 1'b1, 32'h44332211, 4'b1111, 1'b1, 1'b1, 1'b1);
    idleCycles(5);

    $display("[TB] reset mid-beat");
    applyStimulus("midRst", 1'b1, 32'h5A5B5C5D, 4'b1111, 1'b1, 1'b1, 1'b1);
    applyStimulus("midRst", 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    applyStimulus("midRst", 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    checkVal("midRst.lane1", {24'b0, readData}, 32'h0000005C);
    #2;
    reset = 1'b1;
    #1;
    checkVal("midRst.valid", {31'b0, readDataValid}, 32'd0);
    checkVal("midRst.ready", {31'b0, writeDataReady}, 32'd0);
    laneQ.delete();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus("postRst", 1'b1, 32'hA3A2A1A0, 4'b1111, 1'b1, 1'b1, 1'b1);
    applyStimulus("postRst", 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    checkVal("postRst.lane0", {24'b0, readData}, 32'h000000A0);
    idleCycles(4);

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 9) < 7),
                    $urandom(),
                    keepChoice[$urandom_range(0, 5)],
                    $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 9) < 8),
                    ($urandom_range(0, 9) < 7));
    end
    idleCycles(6);
    checkVal("drain.empty", {31'b0, readDataValid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_unpacker.md
Name: data_unpacker

Overview:
- Width down-converter for the data packer datapath: accepts wide stream beats and emits them as a sequence of narrow beats, least-significant lane first.
- Preserves packet boundaries. Uses the writeDataLast / writeDataKeep of the final wide beat to trim the trailing lanes and place readDataLast on the last narrow beat.
- Sits on the read side of the packing FIFO, restoring the original narrow stream.

Parameters:
- InWidth, 32, width of the input data beat in bits.
- OutWidth, 8, width of the output data beat in bits. InWidth must be an integer multiple of OutWidth.
- Ratio (localparam), InWidth/OutWidth, number of output lanes per input beat. Must be at least 2.
- LaneWidth (localparam), $clog2(Ratio), width of the lane index.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  acceptance enable. Low blocks new input beats; a held beat still drains.
- writeData  input  InWidth  wide input beat; lane k is bits [k*OutWidth +: OutWidth].
- writeDataKeep  input  Ratio  lane-valid mask. Contiguous ones from bit 0.
- writeDataValid  input  1  input beat valid.
- writeDataReady  output  1  input beat ready.
- writeDataLast  input  1  input beat ends a packet.
- readData  output  OutWidth  narrow output beat.
- readDataValid  output  1  output beat valid.
- readDataReady  input  1  downstream ready.
- readDataLast  output  1  output beat ends a packet.

Behaviour:
- Reset values: readDataValid=0, readDataLast=0, readData=0, writeDataReady=0 while reset is asserted. Reset also clears the state to IDLE, the lane index to 0, and the hold data/keep/last registers.
- State machine:
  - IDLE: no beat held.
  - SHIFT: a beat is held and lanes are being emitted.
- Acceptance: an input beat is accepted on a rising edge when writeDataValid & writeDataReady.
- writeDataReady = en & (IDLE | (SHIFT & finalLane & readDataReady)). This gives zero-bubble back-to-back operation.
- On acceptance:
  - Store writeData, writeDataKeep and writeDataLast in the hold registers.
  - Set lastLane = index of the highest set keep bit.
  - Set laneIdx to 0 and go to SHIFT.
- Latency: a beat accepted at edge N makes lane 0 visible with readDataValid=1 after edge N, i.e. in the cycle following acceptance.
- Output decode:
  - readData = holdData[laneIdx*OutWidth +: OutWidth].
  - readDataValid = (state==SHIFT).
  - finalLane = (laneIdx==lastLane).
  - readDataLast = SHIFT & holdLast & finalLane.
- Output transfer: an output beat transfers on an edge with readDataValid & readDataReady.
  - If not finalLane: laneIdx increments.
  - If finalLane and a new beat is accepted on the same edge: reload the hold registers and set laneIdx to 0, staying in SHIFT.
  - Otherwise: go to IDLE.
- Stall: while readDataValid & !readDataReady, readData, readDataLast and laneIdx hold stable. Valid never drops without a transfer.
- Zero keep: writeDataKeep=0 on an accepted beat causes the beat to be consumed without output and the state stays/returns to IDLE. Any writeDataLast on that beat is discarded.
- Non-contiguous keep is a protocol violation. Lanes are emitted 0..lastLane regardless of holes.
- Non-last beats are expected to carry full keep. Partial keep on a non-last beat still trims lanes, with no last generated.
- en deassertion mid-beat: draining continues to finalLane. No new beat is taken while en=0.
- Reset asserted mid-beat: outputs drop immediately (asynchronous), the held beat is lost, and the block returns to IDLE.
- readDataReady held low indefinitely: the block holds, and writeDataReady stays 0 once in SHIFT.

Test Plan:
- Single beat: writeData=32'hDDCCBBAA, keep=4'b1111, last=1, readDataReady=1 -> readData AA,BB,CC,DD on 4 consecutive cycles starting the cycle after acceptance; readDataLast=1 only with DD.
- Back-to-back: beats 32'h03020100 and 32'h07060504 (keep=4'b1111, last on the second), ready always 1 -> 8 consecutive valid cycles 00..07 with no bubble; writeDataReady high in the DD-equivalent cycle; last only on 07.
- Partial final beat: 32'h11223344 with keep=4'b0011, last=1 -> outputs 44 then 33 (last=1), then IDLE; lanes 22 and 11 are never emitted.
- Backpressure: readDataReady toggled 1,0,0,1,... during beat 32'hDDCCBBAA -> readData holds BB across the stalled cycles; order AA,BB,CC,DD is preserved; no duplicate or lost lane.
- Zero keep and en: keep=4'b0000, last=1 beat followed by a normal beat with en=0 for 3 cycles -> no output for the first beat; writeDataReady=0 while en=0; the second beat is emitted normally once en=1.
- Reset mid-operation: assert reset while lane 1 is presented -> readDataValid=0 and writeDataReady=0 immediately. After release, the next beat 32'hA3A2A1A0 starts at lane 0 (A0).
